// File: rtl/score_pkg.sv
// Constants and FSM encoding shared by the score RAM and the score controller.
package score_pkg;

  localparam logic [2:0] TEAM_MAX_ADDR = 3'b111;
  localparam int         SCORE_W       = 6;
  localparam int         NUM_IDS       = 7;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/score_ram_array.sv
// Plain synchronous score storage plus the stage-1 read register; no reset on the array.
module score_ram_array #(
  parameter int ADDR_W = 3,
  parameter int WORD_W = 6
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              rd_clr,
  output logic [WORD_W-1:0] rd_s1
);

  logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Read-before-write falls out of the non-blocking update order.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rd_s1 <= rd_clr ? '0 : mem[raddr];
  end

endmodule

// File: rtl/score_ram.sv
// Score RAM with self-clearing sweep and a 2-stage registered read.
// SCORE_RAM_PARITY_EN adds an even-parity bit per entry and a sticky parity_err.
module score_ram
  import score_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = SCORE_W
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  input  logic              clr_req,
  output logic [DATA_W-1:0] q,
  output logic              ready,
  output logic              parity_err
);

`ifdef SCORE_RAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  state_t            state, state_n;
  logic [ADDR_W-1:0] clr_ptr;
  logic              clr_last;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WORD_W-1:0] wdata;
  logic              rd_clr;
  logic [WORD_W-1:0] rd_s1;

  assign clr_last = (clr_ptr == {ADDR_W{1'b1}});

  always_ff @(posedge clock) begin
    if (!rst) state <= CLEAR;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      CLEAR:   if (clr_last) state_n = IDLE;
      IDLE:    if (clr_req)  state_n = CLEAR;
      default: state_n = CLEAR;
    endcase
  end

  always_comb begin
    ready  = (state == IDLE);
    we     = rst && ((state == CLEAR) || wren);
    waddr  = (state == CLEAR) ? clr_ptr : address;
    wdata  = '0;
    rd_clr = !rst || (state == CLEAR);
    if (state == IDLE) begin
`ifdef SCORE_RAM_PARITY_EN
      wdata = {^data, data};
`else
      wdata = data;
`endif
    end
  end

  // Pointer rests at 0 in IDLE so a new sweep always starts at entry 0.
  always_ff @(posedge clock) begin
    if (!rst || state == IDLE) clr_ptr <= '0;
    else                       clr_ptr <= clr_ptr + 1'b1;
  end

  score_ram_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_array (
    .clock  (clock),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr  (address),
    .rd_clr (rd_clr),
    .rd_s1  (rd_s1)
  );

  // rd_s1 is zeroed throughout CLEAR so stale pre-clear words never reach q.
  always_ff @(posedge clock) begin
    if (!rst || state_n == CLEAR) q <= '0;
    else                          q <= rd_s1[DATA_W-1:0];
  end

`ifdef SCORE_RAM_PARITY_EN
  always_ff @(posedge clock) begin
    if (!rst || (state == IDLE && state_n == CLEAR)) parity_err <= 1'b0;
    else if (state == IDLE && (^rd_s1))              parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_score_ram.sv
// Scoreboard bench for score_ram: reads push expected q, popped on the edge q is due.
module tb_score_ram;
  import score_pkg::*;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 6;

  logic              clock;
  logic              rst;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic              clr_req;
  logic [DATA_W-1:0] q;
  logic              ready;
  logic              parity_err;

  score_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock      (clock),
    .rst        (rst),
    .address    (address),
    .data       (data),
    .wren       (wren),
    .clr_req    (clr_req),
    .q          (q),
    .ready      (ready),
    .parity_err (parity_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int    due;
    int    exp;
    string tag;
  } sb_t;

  sb_t             sb[$];
  int              cyc  = 0;
  int              nchk = 0;
  int              nerr = 0;
  logic [DATA_W-1:0] mdl [0:7];

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: inputs launch on the rising edge, outputs checked at the falling edge.
  task automatic step();
    sb_t e;
    @(posedge clock);
    cyc++;
    @(negedge clock);
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk(e.tag, int'(q), e.exp);
    end
  endtask

  task automatic push(input int due, input int exp, input string tag);
    sb_t e;
    e.due = due; e.exp = exp; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic issue_read(input int a, input string tag);
    address = ADDR_W'(a);
    wren    = 1'b0;
    push(cyc + 2, int'(mdl[a]), tag);
    step();
  endtask

  task automatic write(input int a, input int d);
    address = ADDR_W'(a);
    data    = DATA_W'(d);
    wren    = 1'b1;
    mdl[a]  = DATA_W'(d);
    step();
    wren    = 1'b0;
  endtask

  task automatic drain();
    step();
    step();
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mdl[i] = '0;
  endtask

  initial begin
    rst = 1'b0; address = '0; data = 6'h3F; wren = 1'b1; clr_req = 1'b0;
    model_clear();
    step();
    step();
    chk("rst_ready", int'(ready), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_perr", int'(parity_err), 0);

    // Initial sweep with wren held high: ready low for 7 edges, high on the 8th.
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("sweep_ready_%0d", i), int'(ready), (i == 8) ? 1 : 0);
      if (i < 8) chk($sformatf("sweep_q_%0d", i), int'(q), 0);
    end
    wren = 1'b0;
    for (int a = 0; a < 8; a++) issue_read(a, $sformatf("init_rd%0d", a));
    drain();

    // Write then read: q old for one edge, new word after two.
    write(3, 21);
    address = 3'd3;
    push(cyc + 2, 21, "rd3_new");
    step();
    chk("rd3_pre", int'(q), 0);
    step();

    // Same-edge read/write returns the old word; next read sees the new one.
    write(5, 4);
    address = 3'd5; data = 6'd9; wren = 1'b1;
    push(cyc + 2, int'(mdl[5]), "rbw_old");
    mdl[5] = 6'd9;
    step();
    wren = 1'b0;
    issue_read(5, "rbw_new");
    drain();

    // Continuous wren writes on every IDLE edge.
    address = 3'd0; wren = 1'b1;
    for (int a = 0; a < 3; a++) begin
      address = ADDR_W'(a); data = DATA_W'(10 + a); mdl[a] = DATA_W'(10 + a);
      step();
    end
    wren = 1'b0;
    for (int a = 0; a < 3; a++) issue_read(a, $sformatf("burst_rd%0d", a));
    drain();

    // Clear requested while a read of entry 7 is in flight.
    write(7, 40);
    issue_read(7, "rd7_pre_clr");
    drain();
    address = 3'd7;
    push(cyc + 2, 0, "rd7_lost");
    step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    chk("clr_ready_drop", int'(ready), 0);
    model_clear();
    wren = 1'b1; data = 6'h3F; address = 3'd2;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      if (i < 8) chk($sformatf("clr_q_%0d", i), int'(q), 0);
      chk($sformatf("clr_ready_%0d", i), int'(ready), (i == 8) ? 1 : 0);
    end
    wren = 1'b0;
    issue_read(7, "rd7_cleared");
    issue_read(2, "rd2_ignored_wr");
    drain();

    // Reset mid-sweep at clr_ptr=4 restarts from entry 0.
    write(6, 33);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst_mid_ready", int'(ready), 0);
    model_clear();
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("restart_ready_%0d", i), int'(ready), (i == 8) ? 1 : 0);
    end
    issue_read(6, "rd6_after_restart");
    drain();
    chk("perr_idle", int'(parity_err), 0);

`ifdef SCORE_RAM_PARITY_EN
    write(2, 7);
    dut.u_array.mem[2][DATA_W] = ~dut.u_array.mem[2][DATA_W];
    issue_read(2, "perr_rd_data");
    step();
    chk("perr_set", int'(parity_err), 1);
    address = 3'd0;
    step();
    step();
    chk("perr_sticky", int'(parity_err), 1);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    chk("perr_cleared", int'(parity_err), 0);
    for (int i = 0; i < 8; i++) step();
    chk("perr_after_clr", int'(parity_err), 0);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
